// File: rtl/ttfs_readout_pkg.sv
// Shared types and constants for the TTFS output-spike readout block.
package ttfs_readout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } ttfs_state_e;

    // 8'hFF marks "no spike yet"; a real spike at tick 255 cannot be stored.
    localparam logic [7:0] NO_SPIKE       = 8'hFF;
    localparam logic [6:0] REG_STATUS     = 7'd0;
    localparam logic [6:0] REG_WINNER     = 7'd1;
    localparam logic [6:0] REG_TABLE_BASE = 7'd2;

endpackage

// File: rtl/ttfs_readout_first_spike_table.sv
// Per-output-neuron first-spike tick storage: write-once per inference, bulk clear,
// combinational occupancy probe for the capture path and combinational read for the readout mux.
module ttfs_first_spike_table
    import ttfs_readout_pkg::*;
#(
    parameter int N_OUT = 10
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       clear_i,
    input  logic       wr_en_i,
    input  logic [5:0] wr_idx_i,
    input  logic [7:0] wr_data_i,
    input  logic [5:0] chk_idx_i,
    output logic       chk_empty_o,
    input  logic [5:0] rd_idx_i,
    output logic [7:0] rd_data_o
);

    logic [7:0] entry_q [N_OUT];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < N_OUT; i++) entry_q[i] <= NO_SPIKE;
        end else if (clear_i) begin
            for (int i = 0; i < N_OUT; i++) entry_q[i] <= NO_SPIKE;
        end else begin
            // An entry only accepts its first write after a clear.
            for (int i = 0; i < N_OUT; i++) begin
                if (wr_en_i && wr_idx_i == 6'(i) && entry_q[i] == NO_SPIKE)
                    entry_q[i] <= wr_data_i;
            end
        end
    end

    always_comb begin
        chk_empty_o = 1'b0;
        rd_data_o   = NO_SPIKE;
        for (int i = 0; i < N_OUT; i++) begin
            if (chk_idx_i == 6'(i)) chk_empty_o = (entry_q[i] == NO_SPIKE);
            if (rd_idx_i == 6'(i))  rd_data_o   = entry_q[i];
        end
    end

endmodule

// File: rtl/ttfs_readout.sv
// TTFS readout: first-spike capture, earliest/lowest-index winner tracking, completion
// interrupt and a 1-cycle-latency register read port. Optional macro: TTFS_READOUT_EARLY_STOP_EN.
module ttfs_readout
    import ttfs_readout_pkg::*;
#(
    parameter int          N        = 256,
    parameter int          N_OUT    = 10,
    parameter int          OUT_BASE = 246,
    parameter logic [7:0]  TIMEOUT  = 8'd255,
    localparam int         AW       = $clog2(N)
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          clear_i,
    input  logic          spike_i,
    input  logic [AW-1:0] spike_addr_i,
    input  logic [7:0]    tick_i,
    input  logic          inference_done_i,
    input  logic          rd_req_i,
    input  logic [6:0]    rd_addr_i,
    output logic          rd_valid_o,
    output logic [31:0]   rd_data_o,
    output logic          winner_valid_o,
    output logic [5:0]    winner_idx_o,
    output logic          intr_done_o
);

    localparam logic [AW:0] WIN_LO = (AW+1)'(OUT_BASE);
    localparam logic [AW:0] WIN_HI = (AW+1)'(OUT_BASE + N_OUT);

    ttfs_state_e state_q, state_d;
    logic [6:0]  count_q;
    logic        winner_valid_q;
    logic [5:0]  winner_idx_q;
    logic [7:0]  winner_tick_q;
    logic        intr_q, intr_d;
    logic        rd_valid_q;
    logic [31:0] rd_data_q;

    logic        in_window;
    logic [5:0]  cap_idx;
    logic        slot_empty;
    logic        capture;
    logic        win_take;
    logic        done_cond;
    logic [5:0]  tbl_rd_idx;
    logic [7:0]  tbl_rd_data;
    logic [31:0] rd_word;

    assign in_window = ({1'b0, spike_addr_i} >= WIN_LO) && ({1'b0, spike_addr_i} < WIN_HI);
    assign cap_idx   = 6'(spike_addr_i - AW'(OUT_BASE));

    // clear_i wins over a same-cycle spike.
    assign capture  = (state_q == ARMED) && !clear_i && spike_i && in_window && slot_empty;
    assign win_take = capture && (!winner_valid_q || tick_i < winner_tick_q ||
                                  (tick_i == winner_tick_q && cap_idx < winner_idx_q));

    ttfs_first_spike_table #(.N_OUT(N_OUT)) u_table (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .clear_i     (clear_i),
        .wr_en_i     (capture),
        .wr_idx_i    (cap_idx),
        .wr_data_i   (tick_i),
        .chk_idx_i   (cap_idx),
        .chk_empty_o (slot_empty),
        .rd_idx_i    (tbl_rd_idx),
        .rd_data_o   (tbl_rd_data)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        done_cond = (count_q == 7'(N_OUT)) || inference_done_i || (tick_i == TIMEOUT);
`ifdef TTFS_READOUT_EARLY_STOP_EN
        done_cond = done_cond || capture;
`endif
        case (state_q)
            IDLE:    state_d = IDLE;
            ARMED:   if (done_cond) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = ARMED;
        intr_d = (state_q == ARMED) && (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            count_q        <= 7'd0;
            winner_valid_q <= 1'b0;
            winner_idx_q   <= 6'd0;
            winner_tick_q  <= NO_SPIKE;
            intr_q         <= 1'b0;
        end else begin
            intr_q <= intr_d;
            if (clear_i) begin
                count_q        <= 7'd0;
                winner_valid_q <= 1'b0;
                winner_idx_q   <= 6'd0;
                winner_tick_q  <= NO_SPIKE;
            end else if (capture) begin
                count_q <= count_q + 7'd1;
                if (win_take) begin
                    winner_valid_q <= 1'b1;
                    winner_idx_q   <= cap_idx;
                    winner_tick_q  <= tick_i;
                end
            end
        end
    end

    assign tbl_rd_idx = 6'(rd_addr_i - REG_TABLE_BASE);

    // Read mux sees pre-update state, so a read issued in a capture cycle returns old values.
    always_comb begin
        rd_word = 32'h0;
        if (rd_addr_i == REG_STATUS)
            rd_word = {22'b0, state_q, count_q, winner_valid_q};
        else if (rd_addr_i == REG_WINNER)
            rd_word = {16'b0, winner_tick_q, 2'b0, winner_idx_q};
        else if (rd_addr_i >= REG_TABLE_BASE && rd_addr_i < REG_TABLE_BASE + 7'(N_OUT))
            rd_word = {24'b0, tbl_rd_data};
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'h0;
        end else begin
            rd_valid_q <= rd_req_i;
            if (rd_req_i) rd_data_q <= rd_word;
        end
    end

    assign rd_valid_o     = rd_valid_q;
    assign rd_data_o      = rd_data_q;
    assign winner_valid_o = winner_valid_q;
    assign winner_idx_o   = winner_idx_q;
    assign intr_done_o    = intr_q;

endmodule

// File: tb/tb_ttfs_readout.sv
// Self-checking bench for ttfs_readout; read results go through an expected-value queue.
module tb_ttfs_readout;

    localparam int AW = 8;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          clear_i = 1'b0;
    logic          spike_i = 1'b0;
    logic [AW-1:0] spike_addr_i = '0;
    logic [7:0]    tick_i = 8'd0;
    logic          inference_done_i = 1'b0;
    logic          rd_req_i = 1'b0;
    logic [6:0]    rd_addr_i = 7'd0;
    logic          rd_valid_o;
    logic [31:0]   rd_data_o;
    logic          winner_valid_o;
    logic [5:0]    winner_idx_o;
    logic          intr_done_o;

    ttfs_readout dut (
        .CLK              (CLK),
        .RSTN             (RSTN),
        .clear_i          (clear_i),
        .spike_i          (spike_i),
        .spike_addr_i     (spike_addr_i),
        .tick_i           (tick_i),
        .inference_done_i (inference_done_i),
        .rd_req_i         (rd_req_i),
        .rd_addr_i        (rd_addr_i),
        .rd_valid_o       (rd_valid_o),
        .rd_data_o        (rd_data_o),
        .winner_valid_o   (winner_valid_o),
        .winner_idx_o     (winner_idx_o),
        .intr_done_o      (intr_done_o)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_err = 0;
    int          intr_cnt = 0;
    logic [31:0] exp_q[$];
    logic [6:0]  addr_q[$];
    logic [7:0]  exp_tick [10];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Read-port scoreboard and interrupt pulse counter, sampled on the falling edge.
    always @(negedge CLK) begin
        if (RSTN && rd_valid_o) begin
            if (exp_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
            else check($sformatf("rd[%0d]", addr_q.pop_front()), rd_data_o, exp_q.pop_front());
        end
        if (RSTN && intr_done_o) intr_cnt++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    task automatic spike(input int addr, input int t);
        spike_i      = 1'b1;
        spike_addr_i = AW'(addr);
        tick_i       = 8'(t);
        step();
        spike_i      = 1'b0;
    endtask

    task automatic rd(input int addr, input logic [31:0] exp);
        rd_req_i  = 1'b1;
        rd_addr_i = 7'(addr);
        exp_q.push_back(exp);
        addr_q.push_back(7'(addr));
        step();
        rd_req_i = 1'b0;
        check("rd_valid_lat", 32'(rd_valid_o), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        check("rd_drain", exp_q.size(), 0);
    endtask

    task automatic expect_intr(input string tag, input int base);
        int k;
        k = 0;
        while (intr_cnt == base && k < 600) begin
            step();
            k++;
        end
        repeat (4) step();
        check(tag, intr_cnt - base, 1);
    endtask

    task automatic pulse_reset();
        RSTN = 1'b0;
        #3;
        RSTN = 1'b1;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wv"},   32'(winner_valid_o), 32'd0);
        check({tag, "_widx"}, 32'(winner_idx_o),   32'd0);
        check({tag, "_rdv"},  32'(rd_valid_o),     32'd0);
        check({tag, "_rdd"},  rd_data_o,           32'd0);
        check({tag, "_intr"}, 32'(intr_done_o),    32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, order[10], j, tmp, w_idx, w_tick;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("rst");
        RSTN = 1'b1;
        step();
        rd(0, 32'h0000_0000);
        rd(2, 32'h0000_00FF);
        drain();

`ifdef TTFS_READOUT_EARLY_STOP_EN
        // Early exit on first captured spike; read in the capture cycle sees old STATUS.
        do_clear();
        base         = intr_cnt;
        spike_i      = 1'b1;
        spike_addr_i = AW'(249);
        tick_i       = 8'd4;
        rd_req_i     = 1'b1;
        rd_addr_i    = 7'd0;
        exp_q.push_back(32'h0000_0100);
        addr_q.push_back(7'd0);
        step();
        spike_i  = 1'b0;
        rd_req_i = 1'b0;
        check("es_intr_hi", 32'(intr_done_o), 32'd1);
        check("es_widx", 32'(winner_idx_o), 32'd3);
        step();
        check("es_intr_lo", 32'(intr_done_o), 32'd0);
        spike(247, 1);
        spike(250, 2);
        rd(0, 32'h0000_0203);
        rd(3, 32'h0000_00FF);
        rd(5, 32'h0000_0004);
        rd(6, 32'h0000_00FF);
        rd(1, 32'h0000_0403);
        drain();
        check("es_intr_count", intr_cnt - base, 1);
`else
        // Basic capture, repeat ignored
        base = intr_cnt;
        do_clear();
        check("clear_no_intr", intr_cnt - base, 0);
        rd(0, 32'h0000_0100);
        spike(250, 3);
        check("t1_wv", 32'(winner_valid_o), 32'd1);
        check("t1_widx", 32'(winner_idx_o), 32'd4);
        spike(247, 5);
        spike(250, 9);
        rd(6, 32'h0000_0003);
        rd(3, 32'h0000_0005);
        rd(1, 32'h0000_0304);
        rd(0, 32'h0000_0105);
        rd(2, 32'h0000_00FF);
        rd(11, 32'h0000_00FF);
        rd(12, 32'h0000_0000);
        rd(70, 32'h0000_0000);
        drain();

        // Tie: lower index wins despite arriving later
        do_clear();
        spike(252, 7);
        check("tie_first", 32'(winner_idx_o), 32'd6);
        spike(248, 7);
        check("tie_widx", 32'(winner_idx_o), 32'd2);
        rd(1, 32'h0000_0702);
        drain();

        // All ten neurons in random order with random ticks
        do_clear();
        base = intr_cnt;
        for (int i = 0; i < 10; i++) begin
            order[i]    = i;
            exp_tick[i] = 8'($urandom_range(1, 200));
        end
        for (int i = 9; i > 0; i--) begin
            j        = $urandom_range(0, i);
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        w_idx  = 0;
        w_tick = exp_tick[0];
        for (int i = 1; i < 10; i++)
            if (exp_tick[i] < w_tick) begin
                w_idx  = i;
                w_tick = exp_tick[i];
            end
        for (int i = 0; i < 10; i++) spike(246 + order[i], exp_tick[order[i]]);
        expect_intr("all_intr_once", base);
        rd(0, 32'h0000_0215);
        rd(1, {16'b0, 8'(w_tick), 2'b0, 6'(w_idx)});
        for (int i = 0; i < 10; i++) rd(2 + i, {24'b0, exp_tick[i]});
        drain();
        spike(246, 0);
        rd(2, {24'b0, exp_tick[0]});
        rd(0, 32'h0000_0215);
        drain();
        check("all_widx", 32'(winner_idx_o), 32'(w_idx));

        // Timeout with no spikes
        tick_i = 8'd0;
        do_clear();
        base = intr_cnt;
        for (int t = 0; t < 256; t++) begin
            tick_i = 8'(t);
            step();
        end
        expect_intr("to_intr_once", base);
        tick_i = 8'd0;
        check("to_wv", 32'(winner_valid_o), 32'd0);
        rd(0, 32'h0000_0200);
        for (int i = 0; i < 10; i++) rd(2 + i, 32'h0000_00FF);
        drain();

        // inference_done_i ends the inference
        do_clear();
        base = intr_cnt;
        spike(253, 6);
        inference_done_i = 1'b1;
        step();
        inference_done_i = 1'b0;
        expect_intr("infd_intr_once", base);
        rd(0, 32'h0000_0203);
        rd(1, 32'h0000_0607);
        drain();

        // Ignored spikes: out of window, while IDLE, coincident with clear
        do_clear();
        spike(100, 2);
        rd(0, 32'h0000_0100);
        drain();
        pulse_reset();
        spike(247, 2);
        rd(0, 32'h0000_0000);
        rd(3, 32'h0000_00FF);
        drain();
        clear_i      = 1'b1;
        spike_i      = 1'b1;
        spike_addr_i = AW'(250);
        tick_i       = 8'd3;
        step();
        clear_i = 1'b0;
        spike_i = 1'b0;
        rd(0, 32'h0000_0100);
        rd(6, 32'h0000_00FF);
        drain();

        // Asynchronous reset while ARMED
        spike(250, 4);
        rd(0, 32'h0000_0103);
        drain();
        check("pre_rst_rdd", rd_data_o, 32'h0000_0103);
        check("pre_rst_widx", 32'(winner_idx_o), 32'd4);
        #2;
        RSTN = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        step();
        rd(0, 32'h0000_0000);
        rd(6, 32'h0000_00FF);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ttfs_readout.md
Name: ttfs_readout

Overview:
- Downstream consumer of the TTFS charge-mode core's output-spike stream: the per-neuron spike pulse/address and the inference-done flag.
- Records the first-spike tick of each output-layer neuron and tracks the winner, defined as the earliest spike with the lowest index on ties.
- Raises a one-cycle completion interrupt.
- Exposes results through a simple synchronous read port that the team's OBI shim maps into the control address space.

Parameters:
- N, 256, total neuron count; sets the address width AW = $clog2(N).
- N_OUT, 10, number of output-layer neurons, 1..64.
- OUT_BASE, 246, address of the first output neuron; OUT_BASE+N_OUT <= N.
- TIMEOUT, 8'd255, tick value at which an armed inference is forced to DONE.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  asynchronous active-low reset.
- clear_i  in  1  pulse: wipe the table and arm.
- spike_i  in  1  single-cycle output spike strobe.
- spike_addr_i  in  AW  neuron address of the spike.
- tick_i  in  8  current timestep.
- inference_done_i  in  1  level from the spike output stage.
- rd_req_i  in  1  read request.
- rd_addr_i  in  7  word index.
- rd_valid_o  out  1  read data valid, one cycle after rd_req_i.
- rd_data_o  out  32  read data.
- winner_valid_o  out  1  at least one output neuron has spiked.
- winner_idx_o  out  6  winner index relative to OUT_BASE.
- intr_done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, RSTN=0): state=IDLE, every table entry=8'hFF (NO_SPIKE), recorded count=0, winner_valid_o=0, winner_idx_o=0, rd_valid_o=0, rd_data_o=0, intr_done_o=0.
- FSM states IDLE, ARMED, DONE.
  - IDLE -> ARMED on clear_i.
  - ARMED -> DONE on the first of these: count==N_OUT; inference_done_i=1; tick_i==TIMEOUT.
  - DONE -> ARMED on clear_i.
  - clear_i in any state: table <= NO_SPIKE, count <= 0, winner_valid <= 0, next state ARMED. Any spike in the same cycle is ignored.
- Capture, ARMED only: spike_i=1, OUT_BASE <= spike_addr_i < OUT_BASE+N_OUT, and the entry equals NO_SPIKE -> entry <= tick_i, count++.
  - Repeat spikes from the same neuron are ignored.
  - Spikes to addresses outside the window are ignored.
  - Spikes in IDLE or DONE are ignored.
- Winner update happens in the same cycle as capture.
  - Replace the winner if !winner_valid, or tick_i < winner_tick, or (tick_i == winner_tick and idx < winner_idx).
  - winner_valid_o and winner_idx_o are registered and visible the cycle after the spike.
- Completion:
  - intr_done_o pulses exactly one cycle, the cycle after the ARMED->DONE transition.
  - No pulse on reset or on clear_i.
  - If a capture and a completion condition occur in the same cycle, the capture is committed before DONE.
- Read port, 1-cycle latency, always available (including ARMED):
  - Word 0 STATUS = {22'b0, state[1:0], count[6:0], winner_valid}.
  - Word 1 WINNER = {16'b0, winner_tick[7:0], 2'b0, winner_idx[5:0]}.
  - Words 2..2+N_OUT-1 = {24'b0, entry}.
  - Any other index returns 32'h0.
  - rd_data_o holds its last value when rd_req_i=0.
  - Back-to-back reads are allowed every cycle.
- Arithmetic: tick comparisons are unsigned 8-bit. NO_SPIKE=8'hFF is a sentinel, so a genuine spike at tick 255 is unrepresentable. The TIMEOUT default guarantees DONE before such a spike could be stored.

Optional Feature:
- Macro: TTFS_READOUT_EARLY_STOP_EN.
- Defined: ARMED -> DONE additionally on the first captured output spike, and intr_done_o fires the following cycle. This is the classic TTFS early-exit; the table then holds only the winner plus same-cycle spikes.
- Undefined: only the three base conditions end an inference.

Decomposition:
- Package ttfs_readout_pkg holds:
  - state enum typedef ttfs_state_e {IDLE, ARMED, DONE};
  - localparams NO_SPIKE=8'hFF, REG_STATUS=7'd0, REG_WINNER=7'd1, REG_TABLE_BASE=7'd2.
- One sub-module: ttfs_first_spike_table.
  - Holds N_OUT×8 flop storage with write-once-per-inference semantics and clear.
  - Provides a combinational read for the readout mux.
  - The FSM, winner tracker and read port stay in the top module.

Test Plan:
- Reset, clear_i, then spikes at addr 250@tick3, 247@tick5, 250@tick9 -> entries [4]=3 and [1]=5, [4] not overwritten; WINNER idx=4 tick=3; STATUS count=2.
- Tie case: spikes 252 and 248, both at tick 7, on consecutive cycles -> winner_idx_o=2, i.e. the lower index wins despite the later arrival.
- All 10 output neurons spike -> DONE entered when count=10, intr_done_o high exactly one cycle; a further spike causes no table change.
- No spikes, tick_i ramps to 255 -> DONE with winner_valid_o=0; STATUS state=DONE, count=0; every table word reads 0xFF.
- Spike to addr 100, plus spikes while IDLE, then clear_i asserted together with spike_i -> all ignored, count stays 0. Assert RSTN low mid-ARMED -> all outputs return to reset values asynchronously.
- With TTFS_READOUT_EARLY_STOP_EN defined: a single spike at 249@tick4 -> DONE, intr_done_o pulses one cycle after capture, later spikes ignored. Reading word 0 in the capture cycle returns the pre-capture STATUS one cycle later.
